// File: rtl/vote_logger.sv
// Vote-capture stage: debounces four candidate buttons, accepts one vote per
// clean single-button press and keeps saturating per-candidate tallies.
module vote_logger #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic [4:1] button,
    output logic [7:0] cand_1_vote,
    output logic [7:0] cand_2_vote,
    output logic [7:0] cand_3_vote,
    output logic [7:0] cand_4_vote,
    output logic [9:0] total_votes,
    output logic       valid_vote_casted,
    output logic       invalid_press
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TALLY_W = 8;
    localparam int unsigned TOTAL_W = 10;
    localparam int unsigned NCAND   = 4;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] CAST         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

    logic [1:0]         state_q, state_d;
    logic [3:0]         sample_q, sample_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TALLY_W-1:0] tally_q [NCAND];
    logic [TALLY_W-1:0] tally_d [NCAND];
    logic [TOTAL_W-1:0] total_q, total_d;
    logic               valid_q, valid_d;
    logic               invalid_q, invalid_d;

    logic               sample_onehot_c;
    logic [1:0]         sel_c;

    // Decode the latched sample into a candidate index; non-one-hot is a multi-press.
    always_comb begin
        sample_onehot_c = 1'b1;
        sel_c           = 2'd0;
        case (sample_q)
            4'b0001: sel_c = 2'd0;
            4'b0010: sel_c = 2'd1;
            4'b0100: sel_c = 2'd2;
            4'b1000: sel_c = 2'd3;
            default: sample_onehot_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        cnt_d     = cnt_q;
        tally_d   = tally_q;
        total_d   = total_q;
        valid_d   = 1'b0;
        invalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!mode && (button != 4'd0)) begin
                    sample_d = button;
                    cnt_d    = CNT_W'(1);
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (mode || (button != sample_q)) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = CAST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAST: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
                if (sample_onehot_c && (tally_q[sel_c] != TALLY_MAX)) begin
                    tally_d[sel_c] = tally_q[sel_c] + TALLY_W'(1);
                    total_d        = total_q + TOTAL_W'(1);
                    valid_d        = 1'b1;
                end else begin
                    invalid_d = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                // Any activity restarts the release window; mode is ignored here.
                if (button != 4'd0) begin
                    cnt_d = '0;
                end else if ((cnt_q + CNT_W'(1)) == CNT_LIMIT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < NCAND; i++) begin
                tally_q[i] <= '0;
            end
            total_q   <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < NCAND; i++) begin
                tally_q[i] <= tally_d[i];
            end
            total_q   <= total_d;
            valid_q   <= valid_d;
            invalid_q <= invalid_d;
        end
    end

    assign cand_1_vote       = tally_q[0];
    assign cand_2_vote       = tally_q[1];
    assign cand_3_vote       = tally_q[2];
    assign cand_4_vote       = tally_q[3];
    assign total_votes       = total_q;
    assign valid_vote_casted = valid_q;
    assign invalid_press     = invalid_q;

endmodule

// File: tb/tb_vote_logger.sv
// Bench for vote_logger: directed presses checked every cycle against a
// history-window model, plus literal expectations per scenario.
module tb_vote_logger;

    localparam int N    = 4;
    localparam int HMAX = 16384;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic [4:1] button = 4'd0;
    logic [7:0] cand_1_vote, cand_2_vote, cand_3_vote, cand_4_vote;
    logic [9:0] total_votes;
    logic       valid_vote_casted, invalid_press;

    vote_logger #(.DEBOUNCE_CYCLES(N)) dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .button            (button),
        .cand_1_vote       (cand_1_vote),
        .cand_2_vote       (cand_2_vote),
        .cand_3_vote       (cand_3_vote),
        .cand_4_vote       (cand_4_vote),
        .total_votes       (total_votes),
        .valid_vote_casted (valid_vote_casted),
        .invalid_press     (invalid_press)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Model: decisions are made from the recorded input history at each edge.
    bit [3:0] hb [HMAX];
    bit       hm [HMAX];
    int       edge_n    = 0;
    int       mt [4]    = '{0, 0, 0, 0};
    int       m_total   = 0;
    bit       m_valid   = 0;
    bit       m_inv     = 0;
    int       ready_at  = 0;
    int       pend      = -1;
    int       cast_at   = -1;
    bit [3:0] cast_s    = 0;
    bit       releasing = 0;
    int       rel_start = 0;
    bit       model_live = 0;

    function automatic bit window_zero(input int t);
        for (int k = 0; k < N; k++) begin
            if (hb[t-k] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clock) begin : model_blk
        int t;
        int idx;
        t = edge_n;
        if (t >= HMAX) begin
            $display("FAIL history_overflow: got %0d want <%0d", t, HMAX);
            $fatal(1, "history overflow");
        end
        hb[t] = button;
        hm[t] = mode;
        m_valid = 0;
        m_inv   = 0;
        if (reset) begin
            for (int i = 0; i < 4; i++) mt[i] = 0;
            m_total   = 0;
            ready_at  = t + 1;
            pend      = -1;
            cast_at   = -1;
            releasing = 0;
        end else if (cast_at == t) begin
            case (cast_s)
                4'b0001: idx = 0;
                4'b0010: idx = 1;
                4'b0100: idx = 2;
                4'b1000: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0 || mt[idx] == 255) begin
                m_inv = 1;
            end else begin
                mt[idx]++;
                m_total++;
                m_valid = 1;
            end
            cast_at   = -1;
            releasing = 1;
            rel_start = t + 1;
        end else if (releasing) begin
            if (t - N + 1 >= rel_start && window_zero(t)) begin
                releasing = 0;
                ready_at  = t + 1;
            end
        end else if (pend >= 0) begin
            if (hb[t] != hb[pend] || hm[t]) begin
                pend     = -1;
                ready_at = t + 1;
            end else if (t - pend == N) begin
                cast_at = t + 1;
                cast_s  = hb[pend];
                pend    = -1;
            end
        end else if (cast_at < 0 && t >= ready_at && !hm[t] && hb[t] != 0) begin
            pend = t;
        end
        model_live = 1;
        edge_n++;
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("cand_1", cand_1_vote, mt[0]);
            check("cand_2", cand_2_vote, mt[1]);
            check("cand_3", cand_3_vote, mt[2]);
            check("cand_4", cand_4_vote, mt[3]);
            check("total", total_votes, m_total);
            check("valid", valid_vote_casted, m_valid);
            check("invalid", invalid_press, m_inv);
        end
    end

    int cyc = 0;
    int nv = 0;
    int ni = 0;
    int first_v = -1;
    int c0 = 0;

    // One iteration per cycle: observe the last edge's outputs, then drive.
    task automatic step(input logic [3:0] b, input logic md, input int n, input logic rst);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            cyc++;
            if (valid_vote_casted) begin
                nv++;
                if (first_v < 0) first_v = cyc;
            end
            if (invalid_press) ni++;
            button = b;
            mode   = md;
            reset  = rst;
        end
    endtask

    task automatic press(input logic [3:0] b, input logic md);
        step(b, md, N + 3, 1'b0);
        step(4'd0, md, N + 3, 1'b0);
    endtask

    task automatic clear_obs();
        nv = 0;
        ni = 0;
        first_v = -1;
    endtask

    initial begin
        step(4'd0, 1'b0, 3, 1'b1);
        step(4'd0, 1'b0, 2, 1'b0);
        check("rst_cand_1", cand_1_vote, 0);
        check("rst_total", total_votes, 0);
        check("rst_valid", valid_vote_casted, 0);

        // Basic vote: candidate 2, 20-cycle hold
        clear_obs();
        c0 = cyc + 1;
        step(4'b0010, 1'b0, 20, 1'b0);
        step(4'd0, 1'b0, N + 3, 1'b0);
        check("basic_latency", first_v - c0, N + 2);
        check("basic_pulses", nv, 1);
        check("basic_cand_2", cand_2_vote, 1);
        check("basic_total", total_votes, 1);
        check("basic_cand_1", cand_1_vote, 0);

        // Bounce: button[1] high 2 / low 1 for 30 cycles
        clear_obs();
        for (int r = 0; r < 10; r++) begin
            step(4'b0001, 1'b0, 2, 1'b0);
            step(4'd0, 1'b0, 1, 1'b0);
        end
        step(4'd0, 1'b0, N + 3, 1'b0);
        check("bounce_valid", nv, 0);
        check("bounce_invalid", ni, 0);
        check("bounce_cand_1", cand_1_vote, 0);

        // Multi-press: two buttons stable
        clear_obs();
        step(4'b1001, 1'b0, 10, 1'b0);
        step(4'd0, 1'b0, N + 3, 1'b0);
        check("multi_invalid", ni, 1);
        check("multi_valid", nv, 0);
        check("multi_total", total_votes, 1);

        // Saturation: 256 presses on candidate 3 from a clean reset
        step(4'd0, 1'b0, 1, 1'b1);
        step(4'd0, 1'b0, 1, 1'b0);
        clear_obs();
        for (int p = 0; p < 256; p++) press(4'b0100, 1'b0);
        check("sat_valid", nv, 255);
        check("sat_invalid", ni, 1);
        check("sat_cand_3", cand_3_vote, 255);
        check("sat_total", total_votes, 255);

        // Mode gating
        clear_obs();
        step(4'd0, 1'b1, 2, 1'b0);
        press(4'b1000, 1'b1);
        check("gate_valid", nv, 0);
        check("gate_invalid", ni, 0);
        check("gate_cand_4", cand_4_vote, 0);
        press(4'b1000, 1'b0);
        check("ungate_cand_4", cand_4_vote, 1);
        check("ungate_valid", nv, 1);

        // Reset on the second debounce cycle with button[1] held
        clear_obs();
        step(4'b0001, 1'b0, 2, 1'b0);
        step(4'b0001, 1'b0, 1, 1'b1);
        step(4'b0001, 1'b0, 1, 1'b0);
        c0 = cyc;
        check("rreset_cand_3", cand_3_vote, 0);
        check("rreset_cand_4", cand_4_vote, 0);
        check("rreset_total", total_votes, 0);
        check("rreset_invalid", invalid_press, 0);
        step(4'b0001, 1'b0, N + 3, 1'b0);
        step(4'd0, 1'b0, N + 3, 1'b0);
        check("rreset_pulses", nv, 1);
        check("rreset_latency", first_v - c0, N + 2);
        check("rreset_cand_1", cand_1_vote, 1);
        check("rreset_total_after", total_votes, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/vote_logger.md
# vote_logger

Vote-capture stage of the voting machine. Sits between the four raw candidate push-buttons and the mode/display controller. In voting mode it debounces the buttons and accepts exactly one vote per press. It rejects multi-button presses and counter overflow, and keeps per-candidate 8-bit tallies. Each accepted vote produces a one-cycle `valid_vote_casted` pulse, which drives the display controller's LED-flash timer; the tallies feed its result-display path.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a press or a release. Legal range 1..65535.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `mode`  in  1  0 = voting mode, 1 = result mode. In result mode, new presses are ignored.
- `button`  in  4 `[4:1]`  raw candidate buttons, active-high, already synchronised to `clock`.
- `cand_1_vote` .. `cand_4_vote`  out  8 each  per-candidate tally, registered.
- `total_votes`  out  10  sum of accepted votes, registered.
- `valid_vote_casted`  out  1  one-cycle pulse per accepted vote, registered.
- `invalid_press`  out  1  one-cycle pulse per rejected press, registered.

## Operation
- State machine: IDLE, DEBOUNCE, CAST, WAIT_RELEASE. The block also holds a 4-bit `sample` register and a 16-bit stability counter `cnt`.
- **IDLE**
  - If `mode==0` and `button!=0`: latch `button` into `sample`, set `cnt=1`, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- **DEBOUNCE**
  - If `mode==1`: go to IDLE.
  - Else if `button!=sample`: go to IDLE. This is a bounce; no pulse is generated.
  - Else if `cnt==DEBOUNCE_CYCLES`: go to CAST.
  - Else: `cnt` increments by 1.
  - With `DEBOUNCE_CYCLES==1`, the block goes to CAST on the first DEBOUNCE cycle where `button==sample`.
- **CAST** (exactly one cycle; always goes to WAIT_RELEASE with `cnt=0`):
  - If `sample` is one-hot and the selected tally is below 255: that tally increments by 1, `total_votes` increments by 1, and `valid_vote_casted` is set for one cycle.
  - If `sample` is not one-hot (two or more buttons pressed): no tally changes; `invalid_press` is set for one cycle.
  - If the selected tally equals 255: saturation. No tally changes; `invalid_press` is set for one cycle.
- **WAIT_RELEASE**
  - If `button==0`: `cnt` increments by 1. Any nonzero `button` resets `cnt` to 0.
  - Go to IDLE when `cnt` reaches `DEBOUNCE_CYCLES`.
  - `mode` has no effect in this state. A held button therefore never casts a second vote.
- Width rules:
  - Tallies saturate at 255 and never wrap.
  - `total_votes` is 10 bits; its maximum is 4×255 = 1020, so it cannot overflow.
- Both pulses are low in every cycle other than the one following CAST, and they are never high together.
- Reset takes priority over everything:
  - State goes to IDLE; `cnt` and `sample` go to 0.
  - All tallies, `total_votes` and both pulses go to 0.
  - Reset asserted mid-debounce or mid-release abandons the press; no pulse is emitted.
  - A button still held when reset deasserts is treated as a new press.

## Timing
- Reset values: all outputs 0.
- Accept latency:
  - Let edge E0 be the first rising edge at which IDLE samples a stable nonzero `button`.
  - The tally update and `valid_vote_casted` (or `invalid_press`) become visible after edge E0+DEBOUNCE_CYCLES+1.
  - The pulse stays high until edge E0+DEBOUNCE_CYCLES+2.
- Release: after the button drops, the block returns to IDLE once it has seen `DEBOUNCE_CYCLES` consecutive zero cycles in WAIT_RELEASE. The earliest next press is sampled on the following edge.
- `mode` changing to 1 during DEBOUNCE aborts the press at the next edge. A `mode` change during CAST or WAIT_RELEASE does not alter the vote.
- Tallies and pulses are registered outputs. Downstream sees a tally change and its `valid_vote_casted` pulse in the same cycle.

## Test plan
- **Basic vote** (`DEBOUNCE_CYCLES=4`): `mode=0`, hold `button=4'b0010` for 20 cycles, then release.
  - Exactly one `valid_vote_casted` pulse, 5 edges after first sampling.
  - `cand_2_vote=1`, `total_votes=1`; other tallies 0.
- **Bounce rejection**: `button[1]` toggling with a period of 3 cycles for 30 cycles, then 0.
  - No pulses; all tallies remain 0.
- **Multi-press**: hold `button=4'b1001` stable for 10 cycles.
  - One `invalid_press` pulse; all tallies and `total_votes` unchanged.
- **Saturation**: 256 clean presses on `button[3]`.
  - First 255 presses: 255 `valid_vote_casted` pulses; `cand_3_vote=255`, `total_votes=255`.
  - 256th press: `invalid_press` pulses; tally stays 255.
- **Mode gating**: `mode=1`, press `button[4]` cleanly → no pulses, `cand_4_vote=0`. Then `mode=0` and a clean press → `cand_4_vote=1`.
- **Reset mid-debounce**: hold `button[1]`, assert `reset` for 1 cycle on the 2nd DEBOUNCE cycle.
  - All outputs 0 the cycle after reset.
  - Button still held: exactly one vote is accepted `DEBOUNCE_CYCLES+1` edges after reset deasserts, giving `cand_1_vote=1`.
